// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA data RAM arbiter.
// Build option MEMARB_RR_EN selects round-robin arbitration (see mem_arb.sv).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } memarb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } memarb_owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester (CPU, DMA) and RAM-macro signals of the data RAM arbiter.
// slave = arbiter side, master = requesters plus RAM macro.
interface mem_arb_if #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int LENW = 4
);
    logic            cpu_req;
    logic            cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_gnt;
    logic            cpu_rvalid;
    logic [DW-1:0]   cpu_rdata;

    logic            dma_req;
    logic            dma_we;
    logic [AW-1:0]   dma_addr;
    logic [LENW-1:0] dma_len;
    logic [DW-1:0]   dma_wdata;
    logic            dma_gnt;
    logic            dma_rvalid;
    logic [DW-1:0]   dma_rdata;
    logic            dma_done;

    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_done,
        output busy, mem_addr, mem_wen, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_done,
        input  busy, mem_addr, mem_wen, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_burst.sv
// DMA burst tracker: latches base/len/we at burst start, counts beats, makes beat address.
// Beat address wraps modulo 2**AW; last/next_last flag the final and penultimate beats.
module mem_arb_burst #(
    parameter int AW   = 8,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            adv,
    input  logic [AW-1:0]   base,
    input  logic [LENW-1:0] len,
    input  logic            we,
    output logic [AW-1:0]   addr,
    output logic            we_q,
    output logic            last,
    output logic            next_last
);
    logic [AW-1:0]   base_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt;
    logic [LENW-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            we_q   <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            base_q <= base;
            len_q  <= len;
            we_q   <= we;
            cnt    <= '0;
        end else if (adv) begin
            cnt <= last ? '0 : cnt_inc;
        end
    end

    assign cnt_inc   = cnt + 1'b1;
    assign addr      = base_q + AW'(cnt);
    assign last      = (cnt == len_q);
    assign next_last = (cnt_inc == len_q);

endmodule

// File: rtl/mem_arb.sv
// Single-port data RAM arbiter, CPU single beats vs DMA bursts; grant 1 cycle after req, rdata 1 cycle after beat.
// No preemption, one idle bubble after every transaction; MEMARB_RR_EN selects round-robin instead of CPU priority.
module mem_arb #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int LENW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arb_if.slave   bus
);
    import mem_arb_pkg::*;

    memarb_state_t state;
    logic          cpu_gnt_q;
    logic          dma_gnt_q;
    logic          dma_done_q;
    logic          busy_q;
    logic          cpu_rv_q;
    logic          dma_rv_q;
    logic          cpu_win;
    logic          burst_start;
    logic          burst_adv;
    logic [AW-1:0] burst_addr;
    logic          burst_we;
    logic          burst_last;
    logic          burst_next_last;

`ifdef MEMARB_RR_EN
    memarb_owner_t last_owner;
    // On a tie the requester that was not served last wins.
    assign cpu_win = bus.cpu_req && (!bus.dma_req || (last_owner == OWN_DMA));
`else
    assign cpu_win = bus.cpu_req;
`endif

    assign burst_start = (state == ARB_IDLE) && !cpu_win && bus.dma_req;
    assign burst_adv   = (state == ARB_DMA);

    mem_arb_burst #(.AW(AW), .LENW(LENW)) u_burst (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (burst_start),
        .adv       (burst_adv),
        .base      (bus.dma_addr),
        .len       (bus.dma_len),
        .we        (bus.dma_we),
        .addr      (burst_addr),
        .we_q      (burst_we),
        .last      (burst_last),
        .next_last (burst_next_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
            dma_done_q <= 1'b0;
            busy_q     <= 1'b0;
            cpu_rv_q   <= 1'b0;
            dma_rv_q   <= 1'b0;
`ifdef MEMARB_RR_EN
            last_owner <= OWN_DMA;
`endif
        end else begin
            cpu_rv_q <= (state == ARB_CPU) && !bus.cpu_we;
            dma_rv_q <= (state == ARB_DMA) && !burst_we;
            case (state)
                ARB_IDLE: begin
                    if (cpu_win) begin
                        state     <= ARB_CPU;
                        cpu_gnt_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef MEMARB_RR_EN
                        last_owner <= OWN_CPU;
`endif
                    end else if (bus.dma_req) begin
                        state      <= ARB_DMA;
                        dma_gnt_q  <= 1'b1;
                        dma_done_q <= (bus.dma_len == '0);
                        busy_q     <= 1'b1;
`ifdef MEMARB_RR_EN
                        last_owner <= OWN_DMA;
`endif
                    end
                end
                ARB_CPU: begin
                    state     <= ARB_IDLE;
                    cpu_gnt_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                ARB_DMA: begin
                    if (burst_last) begin
                        state      <= ARB_IDLE;
                        dma_gnt_q  <= 1'b0;
                        dma_done_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        // done is registered, so raise it one beat ahead of the last one
                        dma_done_q <= burst_next_last;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    cpu_gnt_q  <= 1'b0;
                    dma_gnt_q  <= 1'b0;
                    dma_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // RAM port follows the current owner; wdata only carries data on write beats.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wen   = 1'b1;
        bus.mem_wdata = '0;
        case (state)
            ARB_CPU: begin
                bus.mem_addr = bus.cpu_addr;
                if (bus.cpu_we) begin
                    bus.mem_wen   = 1'b0;
                    bus.mem_wdata = bus.cpu_wdata;
                end
            end
            ARB_DMA: begin
                bus.mem_addr = burst_addr;
                if (burst_we) begin
                    bus.mem_wen   = 1'b0;
                    bus.mem_wdata = bus.dma_wdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dma_gnt    = dma_gnt_q;
    assign bus.dma_done   = dma_done_q;
    assign bus.busy       = busy_q;
    assign bus.cpu_rvalid = cpu_rv_q;
    assign bus.dma_rvalid = dma_rv_q;
    assign bus.cpu_rdata  = cpu_rv_q ? bus.mem_rdata : '0;
    assign bus.dma_rdata  = dma_rv_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: RAM model, per-requester scoreboards of expected beats and read data.
// Build with +define+MEMARB_RR_EN to check round-robin tie behaviour.
module tb_mem_arb;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int LENW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arb_if #(.AW(AW), .DW(DW), .LENW(LENW)) bus ();

    mem_arb #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h20:   return 16'h1234;
            default: return {a, ~a};
        endcase
    endfunction

    // RAM macro: synchronous read, active-low write enable
    logic [DW-1:0] ram  [0:(1<<AW)-1];
    logic          wr_v [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!bus.mem_wen) begin
            ram[bus.mem_addr]  <= bus.mem_wdata;
            wr_v[bus.mem_addr] <= 1'b1;
        end
        bus.mem_rdata <= (wr_v[bus.mem_addr] === 1'b1) ? ram[bus.mem_addr] : init_val(bus.mem_addr);
    end

    beat_t         cpu_q[$];
    beat_t         dma_q[$];
    logic [DW-1:0] cpu_rq[$];
    logic [DW-1:0] dma_rq[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int total = 0;
    int bad   = 0;
    int last_cpu_rv = -1;
    int last_dma_rv = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int rq_cyc, output int g_cyc);
        beat_t b;
        int n;
        b = '{a, we, d, 1'b1};
        cpu_q.push_back(b);
        if (we) shadow[a] = d;
        else    cpu_rq.push_back(shadow[a]);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        rq_cyc = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_gnt && n < 300);
        if (!bus.cpu_gnt) chk("cpu_gnt_timeout", 0, 1);
        g_cyc = cyc;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [AW-1:0] a, input logic [LENW-1:0] len,
                          input logic [DW-1:0] seed, output int first_cyc, output int done_cyc);
        beat_t b;
        int k;
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            b.addr  = a + AW'(i);
            b.we    = we;
            b.wdata = seed + DW'(i);
            b.last  = (i == int'(len));
            dma_q.push_back(b);
            if (we) shadow[b.addr] = b.wdata;
            else    dma_rq.push_back(shadow[b.addr]);
        end
        @(posedge clk); #1;
        bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_len = len; bus.dma_wdata = seed;
        k = 0; n = 0; first_cyc = -1; done_cyc = -1;
        while (k <= int'(len) && n < 400) begin
            @(negedge clk); n++;
            if (bus.dma_gnt) begin
                if (k == 0) first_cyc = cyc;
                if (bus.dma_done) done_cyc = cyc;
                k++;
                @(posedge clk); #1;
                bus.dma_wdata = seed + DW'(k);
            end
        end
        if (k <= int'(len)) chk("dma_gnt_timeout", k, int'(len) + 1);
        bus.dma_req = 1'b0;
    endtask

    task automatic monitor_cycle();
        beat_t b;
        logic [DW-1:0] e;
        chk("both_gnt", {31'd0, bus.cpu_gnt & bus.dma_gnt}, 0);
        if (bus.cpu_gnt) begin
            if (cpu_q.size() == 0) chk("cpu_gnt_unexpected", 1, 0);
            else begin
                b = cpu_q.pop_front();
                chk("cpu_mem_addr", bus.mem_addr, b.addr);
                chk("cpu_mem_wen", bus.mem_wen, !b.we);
                if (b.we) chk("cpu_mem_wdata", bus.mem_wdata, b.wdata);
            end
        end
        if (bus.dma_gnt) begin
            if (dma_q.size() == 0) chk("dma_gnt_unexpected", 1, 0);
            else begin
                b = dma_q.pop_front();
                chk("dma_mem_addr", bus.mem_addr, b.addr);
                chk("dma_mem_wen", bus.mem_wen, !b.we);
                if (b.we) chk("dma_mem_wdata", bus.mem_wdata, b.wdata);
                chk("dma_done", bus.dma_done, b.last);
            end
        end else if (bus.dma_done) chk("dma_done_stray", 1, 0);
        if (!bus.cpu_gnt && !bus.dma_gnt) begin
            chk("idle_mem_addr", bus.mem_addr, 0);
            chk("idle_mem_wen", bus.mem_wen, 1);
            chk("idle_mem_wdata", bus.mem_wdata, 0);
        end
        if (bus.cpu_rvalid) begin
            last_cpu_rv = cyc;
            if (cpu_rq.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
            else begin e = cpu_rq.pop_front(); chk("cpu_rdata", bus.cpu_rdata, e); end
        end else if (bus.cpu_rdata !== '0) chk("cpu_rdata_idle", bus.cpu_rdata, 0);
        if (bus.dma_rvalid) begin
            last_dma_rv = cyc;
            if (dma_rq.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
            else begin e = dma_rq.pop_front(); chk("dma_rdata", bus.dma_rdata, e); end
        end else if (bus.dma_rdata !== '0) chk("dma_rdata_idle", bus.dma_rdata, 0);
    endtask

    initial begin
        int rq, g, g2, f, d, f2, d2, n, dones;
        bit cpu_first;
        beat_t b;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(AW'(i));

        fork
            forever begin
                @(negedge clk);
                if (rst_n) monitor_cycle();
            end
            begin
                repeat (20000) @(posedge clk);
                $display("FAIL watchdog got=timeout exp=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        #12;
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_dma_gnt", bus.dma_gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dma_done", bus.dma_done, 0);
        chk("rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        chk("rst_mem_wen", bus.mem_wen, 1);
        chk("rst_mem_addr", bus.mem_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: CPU read 0x10
        cpu_op(1'b0, 8'h10, 16'h0, rq, g);
        chk("t1_gnt_latency", g - rq, 1);
        repeat (2) @(posedge clk);
        chk("t1_rvalid_latency", last_cpu_rv - rq, 2);

        // 2: DMA write burst wrapping past 0xFF, then read one word back
        dma_op(1'b1, 8'hFE, 4'd3, 16'hA000, f, d);
        chk("t2_done_on_4th", d - f, 3);
        cpu_op(1'b0, 8'h00, 16'h0, rq, g);

        // 3: simultaneous requests, twice
        fork
            cpu_op(1'b0, 8'h30, 16'h0, rq, g);
            dma_op(1'b0, 8'h31, 4'd1, 16'h0, f, d);
        join
        chk("t3_tie1_cpu_first", {31'd0, g < f}, 1);
        cpu_op(1'b1, 8'h50, 16'h5A5A, rq, g);
        fork
            cpu_op(1'b0, 8'h50, 16'h0, rq, g);
            dma_op(1'b1, 8'h60, 4'd0, 16'hC0DE, f, d);
        join
        cpu_first = (g < f);
`ifdef MEMARB_RR_EN
        chk("t3_tie2_dma_first", {31'd0, cpu_first}, 0);
`else
        chk("t3_tie2_cpu_first", {31'd0, cpu_first}, 1);
`endif

        // 4: CPU request in the middle of an 8-beat burst
        fork
            dma_op(1'b1, 8'h80, 4'd7, 16'h7000, f2, d2);
            begin
                repeat (4) @(posedge clk);
                cpu_op(1'b0, 8'h83, 16'h0, rq, g2);
            end
        join
        chk("t4_cpu_after_bubble", g2 - d2, 2);

        // 5: single-beat DMA read of 0x20
        dma_op(1'b0, 8'h20, 4'd0, 16'h0, f, d);
        chk("t5_done_with_gnt", d - f, 0);
        repeat (2) @(posedge clk);
        chk("t5_rvalid_latency", last_dma_rv - f, 1);

        // 6: reset during beat 2 of a 6-beat read burst
        for (int i = 0; i < 6; i++) begin
            b = '{8'h40 + AW'(i), 1'b0, '0, (i == 5)};
            dma_q.push_back(b);
            dma_rq.push_back(shadow[8'h40 + AW'(i)]);
        end
        @(posedge clk); #1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40; bus.dma_len = 4'd5;
        n = 0; g = 0;
        while (g < 2 && n < 100) begin
            @(negedge clk); n++;
            if (bus.dma_gnt) g++;
        end
        chk("t6_two_beats_seen", g, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.dma_req = 1'b0;
        #1;
        chk("t6_rst_dma_gnt", bus.dma_gnt, 0);
        chk("t6_rst_dma_done", bus.dma_done, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_mem_wen", bus.mem_wen, 1);
        chk("t6_rst_mem_addr", bus.mem_addr, 0);
        chk("t6_rst_rvalid", bus.dma_rvalid, 0);
        dma_q.delete();
        dma_rq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.dma_done || bus.dma_gnt || bus.dma_rvalid) dones++;
        end
        chk("t6_no_activity_after_reset", dones, 0);

        repeat (4) @(posedge clk);
        chk("end_cpu_q_empty", cpu_q.size() + cpu_rq.size(), 0);
        chk("end_dma_q_empty", dma_q.size() + dma_rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
